// File: rtl/security_engine.sv
// Key-gated encode/decode engine with a restoring divide-by-3 for decode and
// lockout after MAX_FAIL consecutive key rejections.
//
// state  | meaning
// IDLE   | ready for a request
// CALC   | computing result (1 cycle encode, DATA_W cycles decode)
// DONE   | result presented, waiting for out_ready
// LOCKED | too many bad keys; absorbing until rst
module security_engine #(
  parameter int               DATA_W   = 32,
  parameter int               KEY_W    = 16,
  parameter logic [KEY_W-1:0] KEY_MEM  = 16'h0032,
  parameter logic [KEY_W-1:0] KEY_REG  = 16'h0032,
  parameter int               MAX_FAIL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_err,
  output logic              locked
);

  localparam int CW = $clog2(DATA_W);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  typedef enum logic [1:0] {IDLE, CALC, DONE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [1:0]        r_q, r_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     fail_q, fail_d;
  logic              locked_q, locked_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_err_q, out_err_d;

  logic              accept, key_good, q_bit;
  logic [2:0]        trial;
  logic [1:0]        r_sub;
  logic [DATA_W-1:0] q_next, enc_res, dec_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      a_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      locked_q   <= 1'b0;
      data_out_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
      data_out_q <= data_out_d;
      out_err_q  <= out_err_d;
    end
  end

  // Remainder stays below 3, so a 2-bit remainder and 3-bit trial suffice.
  always_comb begin
    accept   = in_valid && (state_q == IDLE);
    key_good = mode ? (key_in == KEY_REG) : (key_in == KEY_MEM);
    trial    = {r_q, a_q[DATA_W-1]};
    q_bit    = (trial >= 3'd3);
    r_sub    = 2'(trial - 3'd3);
    q_next   = {a_q[DATA_W-2:0], q_bit};
    enc_res  = (((a_q - DATA_W'(3)) ^ DATA_W'(2)) + DATA_W'(9)) * DATA_W'(3);
    dec_res  = ((q_next - DATA_W'(9)) ^ DATA_W'(2)) + DATA_W'(3);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = key_good ? CALC : DONE;
      CALC:    if (!mode_q || cnt_q == '0) state_d = DONE;
      DONE:    if (out_ready) state_d = (fail_q == FAIL_MAX) ? LOCKED : IDLE;
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    a_d        = a_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    data_out_d = data_out_q;
    out_err_d  = out_err_q;
    if (state_q == IDLE && accept) begin
      mode_d = mode;
      a_d    = data_in;
      r_d    = '0;
      cnt_d  = CW'(DATA_W - 1);
      if (key_good) begin
        fail_d = '0;
      end else begin
        fail_d     = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;
        data_out_d = '0;
        out_err_d  = 1'b1;
      end
    end else if (state_q == CALC) begin
      if (mode_q) begin
        a_d   = q_next;
        r_d   = q_bit ? r_sub : trial[1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          data_out_d = dec_res;
          out_err_d  = 1'b0;
        end
      end else begin
        data_out_d = enc_res;
        out_err_d  = 1'b0;
      end
    end
    locked_d = (fail_d == FAIL_MAX);
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    data_out  = data_out_q;
    out_err   = out_err_q;
    locked    = locked_q;
  end

endmodule

// File: doc/security_engine.md
SECURITY_ENGINE -- requirements
Module: security_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the data path width; legal values are 8 and above.
REQ-002 The block SHALL have parameter KEY_W, default 16, the key width.
REQ-003 The block SHALL have parameter KEY_MEM, default 16'h0032, the key that authorises encode.
REQ-004 The block SHALL have parameter KEY_REG, default 16'h0032, the key that authorises decode.
REQ-005 The block SHALL have parameter MAX_FAIL, default 3, the consecutive bad-key count that triggers lockout; legal values are 1 and above.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 = encode, 1 = decode.
REQ-011 The block SHALL have port data_in, input, DATA_W bits: the operand.
REQ-012 The block SHALL have port key_in, input, KEY_W bits: the access key.
REQ-013 The block SHALL have port out_valid, output, 1 bit: a result is present.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-015 The block SHALL have port data_out, output, DATA_W bits: the result.
REQ-016 The block SHALL have port out_err, output, 1 bit: the result is a key rejection.
REQ-017 The block SHALL have port locked, output, 1 bit: lockout is active.

Function
REQ-018 The FSM SHALL have states IDLE, CALC, DONE and LOCKED; in_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on a clock edge where in_valid && in_ready; the block SHALL capture mode, data_in and key_in on that edge and ignore them afterwards.
REQ-020 Key check at acceptance: a key is good if (mode=0 and key_in==KEY_MEM) or (mode=1 and key_in==KEY_REG).
REQ-021 Good key: the block SHALL enter CALC and clear the fail counter.
REQ-022 Bad key: the block SHALL go directly to DONE with data_out=0 and out_err=1, and increment the fail counter, saturating at MAX_FAIL.
REQ-023 Encode result SHALL be ((((d - 3) ^ 2) + 9) * 3), all mod 2^DATA_W, where ^ is bitwise XOR; CALC SHALL last exactly 1 cycle.
REQ-024 Decode result SHALL be ((((d / 3) - 9) ^ 2) + 3), mod 2^DATA_W, where / is unsigned floor division by a sequential restoring divider at 1 quotient bit per cycle; CALC SHALL last exactly DATA_W cycles.
REQ-025 Latency with acceptance at edge T: out_valid SHALL rise after edge T+2 for encode, T+1+DATA_W for decode, and T+1 for a bad key.
REQ-026 In DONE, out_valid=1 and data_out and out_err SHALL stay stable until out_ready=1; the handshake edge SHALL leave DONE.
REQ-027 On leaving DONE, the block SHALL go to LOCKED if the fail counter == MAX_FAIL, otherwise to IDLE.
REQ-028 locked SHALL assert on the same edge the counter reaches MAX_FAIL.
REQ-029 LOCKED SHALL be absorbing until rst, with in_ready=0 and out_valid=0.
REQ-030 A good key SHALL fully clear the counter; only consecutive failures count.
REQ-031 out_err SHALL be 0 for every good-key result.
REQ-032 Outside DONE, out_valid=0; data_out and out_err SHALL hold their last values.

Reset
REQ-033 rst SHALL have priority over all activity, in any state including mid-division.
REQ-034 On rst, the block SHALL go to IDLE with: in_ready=1, out_valid=0, data_out=0, out_err=0, locked=0, fail counter=0, and the divider cleared.
REQ-035 A request in flight when rst asserts SHALL be discarded with no output produced.
REQ-036 in_ready SHALL be high on the first cycle after rst deasserts.

Verification
REQ-037 Encode, DATA_W=32, d=10, key 0x0032, out_ready=1 -> data_out=0x0000002A, out_err=0, out_valid exactly 2 cycles after acceptance.
REQ-038 Decode d=0x2A, key 0x0032 -> data_out=0x0000000A after 33 cycles; a roundtrip of d=10 SHALL match.
REQ-039 Encode d=0 -> wraparound: 0xFFFFFFFD ^ 2 = 0xFFFFFFFF, +9 = 8, *3 -> data_out=0x00000018.
REQ-040 Three consecutive bad keys (MAX_FAIL=3) -> three results with out_err=1 and data_out=0; locked=1 on the third; in_ready stays 0 afterwards until rst; a good key between failures resets the count.
REQ-041 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, data_out and out_err stay stable and in_ready=0; release -> exactly one transfer.
REQ-042 Assert rst at decode cycle 16 -> next cycle IDLE, all outputs at reset values, and no out_valid pulse.
